// File: rtl/mm_responder.sv
// Main-memory responder for the data cache's miss/write-back port: accepts one
// read or write, completes it after LATENCY edges and pulses ready for one cycle.
module mm_responder #(
  parameter int DM_DATA_W_m1 = 7,
  parameter int DM_ADDR_W_m1 = 7,
  parameter int LATENCY      = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mm_read,
  input  logic                    mm_write,
  input  logic [DM_ADDR_W_m1:0]   addr,
  input  logic [DM_DATA_W_m1:0]   wdata,
  output logic [DM_DATA_W_m1:0]   rdata,
  output logic                    ready,
  output logic                    busy
);

  localparam int          DEPTH    = 2 ** (DM_ADDR_W_m1 + 1);
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   op_wr_q, op_wr_d;
  logic [DM_ADDR_W_m1:0]  addr_q, addr_d;
  logic [DM_DATA_W_m1:0]  wdata_q, wdata_d;
  logic [DM_DATA_W_m1:0]  rdata_q, rdata_d;
  logic [DM_DATA_W_m1:0]  mem_q [DEPTH];
  logic                   commit_s;

  // The array access happens on the BUSY->DONE edge, so DONE already sees the result.
  assign commit_s = (state_q == BUSY) && (cnt_q == 4'd0);

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (mm_write || mm_read) begin
          state_d = BUSY;
          op_wr_d = mm_write;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = DONE;
          if (!op_wr_q) begin
            rdata_d = mem_q[addr_q];
          end else begin
            rdata_d = rdata_q;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and latched-request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (commit_s && op_wr_q) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  assign rdata = rdata_q;
  assign ready = (state_q == DONE);
  assign busy  = (state_q != IDLE);

endmodule
